// File: rtl/store_buffer_if.sv
// Signal bundle between the core write port, the store buffer and the data memory.
// The buffer uses the slave modport; the driving side (core/memory model) uses master.
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              MemWrite;
    logic [AW-1:0]     DataAdr;
    logic [DW-1:0]     WriteData;
    logic [DW/8-1:0]   ByteEn;
    logic              stall;
    logic              mem_valid;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_be;
    logic              mem_ready;
    logic [AW-1:0]     ld_addr;
    logic              ld_hit;
    logic [DW-1:0]     ld_data;
    logic [DW/8-1:0]   ld_bvalid;
    logic              empty;
    logic [CW-1:0]     count;

    modport slave (
        input  MemWrite, DataAdr, WriteData, ByteEn, mem_ready, ld_addr,
        output stall, mem_valid, mem_addr, mem_wdata, mem_be,
               ld_hit, ld_data, ld_bvalid, empty, count
    );

    modport master (
        output MemWrite, DataAdr, WriteData, ByteEn, mem_ready, ld_addr,
        input  stall, mem_valid, mem_addr, mem_wdata, mem_be,
               ld_hit, ld_data, ld_bvalid, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// In-order FIFO store buffer draining core stores to memory over valid/ready.
// Define STORE_BUF_FWD_EN to build store-to-load forwarding; otherwise ld_* are tied 0.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = DW / 8;

    typedef struct packed {
        logic [AW-3:0] word;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } entry_t;

    entry_t        buf_q [DEPTH];
    entry_t        new_entry;
    entry_t        head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, is_empty, push, pop;

    // Full/empty come from the count so equal pointers are never ambiguous.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        is_empty  = (count_q == '0);
        push      = bus.MemWrite && !full;
        pop       = !is_empty && bus.mem_ready;
        new_entry = '{word: bus.DataAdr[AW-1:2], data: bus.WriteData, be: bus.ByteEn};
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: entry storage has no reset; every read of it is qualified by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= new_entry;
        end
    end

    assign head          = buf_q[rd_ptr_q];
    assign bus.stall     = full;
    assign bus.mem_valid = !is_empty;
    assign bus.mem_addr  = is_empty ? '0 : {head.word, 2'b00};
    assign bus.mem_wdata = is_empty ? '0 : head.data;
    assign bus.mem_be    = is_empty ? '0 : head.be;
    assign bus.empty     = is_empty;
    assign bus.count     = count_q;

`ifdef STORE_BUF_FWD_EN
    logic [PW-1:0] slot;
    logic [DW-1:0] fwd_data;
    logic [BW-1:0] fwd_be;
    logic          unused_ok;

    // Walk oldest to youngest so the youngest matching store wins each lane.
    always_comb begin
        fwd_data = '0;
        fwd_be   = '0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (buf_q[slot].word == bus.ld_addr[AW-1:2])) begin
                for (int b = 0; b < BW; b++) begin
                    if (buf_q[slot].be[b]) begin
                        fwd_data[8*b +: 8] = buf_q[slot].data[8*b +: 8];
                        fwd_be[b]          = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.ld_hit    = |fwd_be;
    assign bus.ld_data   = fwd_data;
    assign bus.ld_bvalid = fwd_be;
    assign unused_ok     = ^{bus.DataAdr[1:0], bus.ld_addr[1:0]};
`else
    logic unused_ok;

    assign bus.ld_hit    = 1'b0;
    assign bus.ld_data   = '0;
    assign bus.ld_bvalid = '0;
    assign unused_ok     = ^{bus.DataAdr[1:0], bus.ld_addr};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Randomized self-checking bench for store_buffer against a queue-based reference model.
// Forwarding expectations follow STORE_BUF_FWD_EN when the bench is built with it.
module tb_store_buffer;
    localparam int DEPTH = 4;

`ifdef STORE_BUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } st_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    st_t  q[$];
    st_t  exp_drained[$];
    st_t  act_drained[$];

    store_buffer_if #(.DEPTH(DEPTH), .AW(32), .DW(32)) bus ();

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_inputs(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, input logic rdy);
        bus.MemWrite  = we;
        bus.DataAdr   = a;
        bus.WriteData = d;
        bus.ByteEn    = be;
        bus.mem_ready = rdy;
    endtask

    // Advance the model by one clock using the inputs currently driven, then wait past the edge.
    task automatic tick();
        st_t e;
        bit  do_pop, do_push;
        do_pop  = (q.size() != 0) && bus.mem_ready;
        do_push = bus.MemWrite && (q.size() < DEPTH);
        if (bus.mem_valid && bus.mem_ready) begin
            e.addr = bus.mem_addr;
            e.data = bus.mem_wdata;
            e.be   = bus.mem_be;
            act_drained.push_back(e);
        end
        if (do_pop) exp_drained.push_back(q.pop_front());
        if (do_push) begin
            e.addr = bus.DataAdr & ~32'h3;
            e.data = bus.WriteData;
            e.be   = bus.ByteEn;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Forwarding reference: merge matching pending stores oldest to youngest.
    function automatic void fwd_model(input logic [31:0] la, output logic hit,
                                      output logic [31:0] d, output logic [3:0] bv);
        d  = '0;
        bv = '0;
        if (FWD) begin
            foreach (q[i]) begin
                if (q[i].addr[31:2] == la[31:2]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (q[i].be[b]) begin
                            d[8*b +: 8] = q[i].data[8*b +: 8];
                            bv[b] = 1'b1;
                        end
                    end
                end
            end
        end
        hit = |bv;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        set_inputs(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        bus.ld_addr = 32'h0;
        #10;
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %0b want 0", bus.mem_valid); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", bus.stall); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %0b want 1", bus.empty); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus.count); end
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 68'h0) begin
            errors++; $display("FAIL rst_payload got %h/%h/%h want 0", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
        checks++; if ({bus.ld_hit, bus.ld_bvalid, bus.ld_data} !== 37'h0) begin
            errors++; $display("FAIL rst_ld got %b/%h/%h want 0", bus.ld_hit, bus.ld_bvalid, bus.ld_data); end
        #12;
        reset = 1'b1;
        @(posedge clk);
        #1;
        set_inputs(1'b1, 32'd100, 32'd25, 4'hF, 1'b1);
        tick();
        set_inputs(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        #1;
        checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %0b want 1", bus.mem_valid); end
        checks++; if (bus.mem_addr !== 32'd100) begin errors++; $display("FAIL first_addr got %0d want 100", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'd25) begin errors++; $display("FAIL first_wdata got %0d want 25", bus.mem_wdata); end
        checks++; if (bus.mem_be !== 4'hF) begin errors++; $display("FAIL first_be got %h want f", bus.mem_be); end
        tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL first_drained_empty got %0b want 1", bus.empty); end
        exp_drained.delete();
        act_drained.delete();
    endtask

    task automatic test_full();
        logic [31:0] d[5];
        for (int k = 0; k < 5; k++) d[k] = $urandom;
        for (int k = 0; k < 5; k++) begin
            set_inputs(1'b1, 32'(4 * k), d[k], 4'hF, 1'b0);
            #1;
            if (k == 4) begin
                checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL full_stall got %0b want 1", bus.stall); end
            end
            tick();
        end
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", bus.count); end
        set_inputs(1'b1, 32'd16, d[4], 4'hF, 1'b1);
        #1;
        checks++; if (bus.mem_addr !== 32'd0) begin errors++; $display("FAIL full_head got %0d want 0", bus.mem_addr); end
        tick();
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL full_unstall got %0b want 0", bus.stall); end
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_after_pop got %0d want 3", bus.count); end
        set_inputs(1'b1, 32'd16, d[4], 4'hF, 1'b0);
        tick();
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_held_push got %0d want 4", bus.count); end
        set_inputs(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        checks++; if (act_drained.size() != 5) begin errors++; $display("FAIL full_drain_len got %0d want 5", act_drained.size()); end
        foreach (act_drained[i]) begin
            checks++;
            if (act_drained[i].addr !== 32'(4 * i) || act_drained[i].data !== d[i]) begin
                errors++; $display("FAIL full_drain[%0d] got %h/%h want %h/%h", i, act_drained[i].addr,
                                   act_drained[i].data, 32'(4 * i), d[i]);
            end
        end
        exp_drained.delete();
        act_drained.delete();
    endtask

    task automatic test_stability();
        for (int k = 0; k < 2; k++) begin
            set_inputs(1'b1, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), 1'b0);
            tick();
        end
        set_inputs(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.mem_valid !== 1'b1 || bus.mem_addr !== q[0].addr || bus.mem_wdata !== q[0].data) begin
                errors++; $display("FAIL hold[%0d] got %b/%h/%h want 1/%h/%h", k, bus.mem_valid, bus.mem_addr,
                                   bus.mem_wdata, q[0].addr, q[0].data);
            end
            tick();
        end
        set_inputs(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        tick();
        tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL hold_empty got %0b want 1", bus.empty); end
        checks++; if (act_drained.size() != 2) begin errors++; $display("FAIL hold_drain_len got %0d want 2", act_drained.size()); end
        foreach (exp_drained[i]) if (i < act_drained.size()) begin
            checks++;
            if (act_drained[i] !== exp_drained[i]) begin
                errors++; $display("FAIL hold_order[%0d] got %h want %h", i, act_drained[i], exp_drained[i]);
            end
        end
        exp_drained.delete();
        act_drained.delete();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) begin
            set_inputs(1'b1, $urandom, $urandom, 4'($urandom), 1'b1);
            tick();
            checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 1", k, bus.count); end
        end
        set_inputs(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %0b want 1", bus.empty); end
        checks++; if (act_drained.size() != 12) begin errors++; $display("FAIL b2b_drain_len got %0d want 12", act_drained.size()); end
        foreach (exp_drained[i]) if (i < act_drained.size()) begin
            checks++;
            if (act_drained[i] !== exp_drained[i]) begin
                errors++; $display("FAIL b2b_order[%0d] got %h want %h", i, act_drained[i], exp_drained[i]);
            end
        end
        exp_drained.delete();
        act_drained.delete();
    endtask

    task automatic test_forward();
        set_inputs(1'b1, 32'd96, 32'h1122_3344, 4'hF, 1'b0);
        tick();
        set_inputs(1'b1, 32'd96, 32'hAABB_CCDD, 4'b0011, 1'b0);
        tick();
        set_inputs(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        bus.ld_addr = 32'd97;
        #1;
        checks++;
        if (bus.ld_hit !== FWD || bus.ld_bvalid !== (FWD ? 4'hF : 4'h0) || bus.ld_data !== (FWD ? 32'h1122_CCDD : 32'h0)) begin
            errors++; $display("FAIL fwd_merge got %b/%h/%h", bus.ld_hit, bus.ld_bvalid, bus.ld_data);
        end
        bus.ld_addr = 32'd200;
        #1;
        checks++; if (bus.ld_hit !== 1'b0 || bus.ld_bvalid !== 4'h0) begin
            errors++; $display("FAIL fwd_miss got %b/%h want 0/0", bus.ld_hit, bus.ld_bvalid); end
        bus.ld_addr = 32'd97;
        set_inputs(1'b1, 32'd96, 32'hFFFF_FFFF, 4'b1000, 1'b0);
        #1;
        checks++; if (bus.ld_data !== (FWD ? 32'h1122_CCDD : 32'h0)) begin
            errors++; $display("FAIL fwd_push_excluded got %h", bus.ld_data); end
        tick();
        set_inputs(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        #1;
        checks++; if (bus.ld_data !== (FWD ? 32'hFF22_CCDD : 32'h0)) begin
            errors++; $display("FAIL fwd_pop_included got %h", bus.ld_data); end
        tick();
        checks++;
        if (bus.ld_bvalid !== (FWD ? 4'b1011 : 4'h0) || bus.ld_data !== (FWD ? 32'hFF00_CCDD : 32'h0)) begin
            errors++; $display("FAIL fwd_partial got %h/%h", bus.ld_bvalid, bus.ld_data);
        end
        tick();
        tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fwd_empty got %0b want 1", bus.empty); end
        exp_drained.delete();
        act_drained.delete();
    endtask

    task automatic test_random();
        logic        e_hit;
        logic [31:0] e_data;
        logic [3:0]  e_bv;
        for (int k = 0; k < 400; k++) begin
            set_inputs(1'($urandom_range(0, 1)), 32'(96 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3)),
                       $urandom, 4'($urandom), 1'($urandom_range(0, 2) == 0));
            bus.ld_addr = 32'(96 + 4 * $urandom_range(0, 4) + $urandom_range(0, 3));
            #1;
            fwd_model(bus.ld_addr, e_hit, e_data, e_bv);
            checks++;
            if (bus.stall !== (q.size() == DEPTH) || bus.empty !== (q.size() == 0) ||
                bus.mem_valid !== (q.size() != 0) || bus.count !== 3'(q.size())) begin
                errors++; $display("FAIL rand_status[%0d] got st=%b em=%b v=%b c=%0d want count %0d", k, bus.stall,
                                   bus.empty, bus.mem_valid, bus.count, q.size());
            end
            if (q.size() != 0) begin
                checks++;
                if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== q[0]) begin
                    errors++; $display("FAIL rand_head[%0d] got %h/%h/%h want %h", k, bus.mem_addr, bus.mem_wdata,
                                       bus.mem_be, q[0]);
                end
            end
            checks++;
            if (bus.ld_hit !== e_hit || bus.ld_bvalid !== e_bv || bus.ld_data !== e_data) begin
                errors++; $display("FAIL rand_fwd[%0d] got %b/%h/%h want %b/%h/%h", k, bus.ld_hit, bus.ld_bvalid,
                                   bus.ld_data, e_hit, e_bv, e_data);
            end
            tick();
        end
        set_inputs(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        for (int k = 0; k <= DEPTH; k++) tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rand_empty got %0b want 1", bus.empty); end
        checks++; if (act_drained.size() != exp_drained.size()) begin
            errors++; $display("FAIL rand_drain_len got %0d want %0d", act_drained.size(), exp_drained.size()); end
        foreach (exp_drained[i]) if (i < act_drained.size()) begin
            checks++;
            if (act_drained[i] !== exp_drained[i]) begin
                errors++; $display("FAIL rand_order[%0d] got %h want %h", i, act_drained[i], exp_drained[i]);
            end
        end
        exp_drained.delete();
        act_drained.delete();
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 3; k++) begin
            set_inputs(1'b1, 32'(64 + 4 * k), $urandom, 4'hF, 1'b0);
            tick();
        end
        set_inputs(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %0b want 0", bus.mem_valid); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL mrst_count got %0d want 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mrst_empty got %0b want 1", bus.empty); end
        q.delete();
        exp_drained.delete();
        act_drained.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL mrst_stale[%0d] got %0b want 0", k, bus.mem_valid); end
            tick();
        end
        set_inputs(1'b1, 32'h0000_0A04, 32'h5A5A_0001, 4'h3, 1'b0);
        tick();
        checks++; if (bus.mem_addr !== 32'h0000_0A04 || bus.count !== 3'd1) begin
            errors++; $display("FAIL mrst_fresh got %h/%0d want a04/1", bus.mem_addr, bus.count); end
    endtask

    initial begin
        test_reset();
        test_full();
        test_stability();
        test_back_to_back();
        test_forward();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
